// File: rtl/ring_seq_checker.sv
// ring_seq_checker: decodes and checks a one-hot ring code, tracks lock, counts errors.
// Ports: clk, reset (sync, active-high), ring_valid, ring_in[WIDTH], err_clr ->
//   idx[IDX_W], idx_valid, onehot_ok, wrap, locked, seq_err, err_count[ERR_W].
// Build option: define RING_SEQ_CHECKER_ERR_CNT_EN to build err_count/err_clr;
//   otherwise err_count is tied to 0 and err_clr is ignored.
module ring_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ring_valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             onehot_ok,
    output logic             wrap,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
    localparam logic [WIDTH-1:0] LSB_CODE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQ,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             onehot_ok_q, onehot_ok_d;
    logic             wrap_q, wrap_d;
    logic             seq_err_q, seq_err_d;

    logic             is_zero;
    logic             is_onehot;
    logic [WIDTH-1:0] succ;
    logic [IDX_W-1:0] dec_idx;
    logic [CNT_W-1:0] good_adv;

    always_comb begin
        is_zero   = (ring_in == '0);
        is_onehot = $onehot(ring_in);
        // From zero or the last position the ring restarts at the MSB.
        succ = ((prev_q == '0) || (prev_q == LSB_CODE)) ? MSB_CODE : (prev_q >> 1);
        dec_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (ring_in[k]) begin
                dec_idx = IDX_W'(WIDTH - 1 - k);
            end
        end
        // Only ONEHOT->ONEHOT transitions count towards lock.
        good_adv = (prev_q != '0) ? good_cnt_q + CNT_W'(1) : '0;
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        idx_d       = idx_q;
        onehot_ok_d = onehot_ok_q;
        idx_valid_d = 1'b0;
        wrap_d      = 1'b0;
        seq_err_d   = 1'b0;
        if (ring_valid) begin
            if (is_zero) begin
                onehot_ok_d = 1'b1;
                seq_err_d   = (state_q == LOCKED);
                prev_d      = '0;
                state_d     = UNLOCKED;
                good_cnt_d  = '0;
            end else if (!is_onehot) begin
                onehot_ok_d = 1'b0;
                seq_err_d   = 1'b1;
                prev_d      = '0;
                state_d     = UNLOCKED;
                good_cnt_d  = '0;
            end else begin
                onehot_ok_d = 1'b1;
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
                prev_d      = ring_in;
                if (ring_in == succ) begin
                    wrap_d = (prev_q == LSB_CODE);
                    if (state_q != LOCKED) begin
                        if (good_adv >= LOCK_V) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            state_d    = ACQ;
                            good_cnt_d = good_adv;
                        end
                    end
                end else begin
                    // Resync onto the received code and start over.
                    seq_err_d  = 1'b1;
                    state_d    = UNLOCKED;
                    good_cnt_d = '0;
                end
            end
        end
    end

`ifdef RING_SEQ_CHECKER_ERR_CNT_EN
    logic [ERR_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (seq_err_d) begin
            if (err_clr) begin
                err_count_d = ERR_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end else if (err_clr) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            onehot_ok_q <= 1'b1;
            wrap_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            onehot_ok_q <= onehot_ok_d;
            wrap_q      <= wrap_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign onehot_ok = onehot_ok_q;
    assign wrap      = wrap_q;
    assign locked    = (state_q == LOCKED);
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// tb_ring_seq_checker: scoreboard bench for ring_seq_checker (WIDTH=4, LOCK_CNT=4, ERR_W=2).
// Expected outputs are pushed by a reference model as stimulus is driven.
module tb_ring_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       ring_valid;
    logic [3:0] ring_in;
    logic       err_clr;
    logic [1:0] idx;
    logic       idx_valid;
    logic       onehot_ok;
    logic       wrap;
    logic       locked;
    logic       seq_err;
    logic [1:0] err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_seq_checker #(
        .WIDTH   (4),
        .LOCK_CNT(4),
        .ERR_W   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ring_valid(ring_valid),
        .ring_in   (ring_in),
        .err_clr   (err_clr),
        .idx       (idx),
        .idx_valid (idx_valid),
        .onehot_ok (onehot_ok),
        .wrap      (wrap),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    // Reference model state. m_state: 0 unlocked, 1 acquiring, 2 locked.
    logic [3:0] m_prev;
    int         m_state;
    int         m_good;
    logic [1:0] m_idx;
    logic       m_ok;
    int         m_err;

    logic [8:0] sb[$];
    logic [8:0] exp_v;
    logic [8:0] act_v;

    function automatic logic [8:0] actual();
        return {idx, idx_valid, onehot_ok, wrap, locked, seq_err, err_count};
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] c,
                        input logic clr);
        logic [3:0] succ;
        logic       iv, wr, er;
        int         ones;
        iv = 0; wr = 0; er = 0;
        if (r) begin
            m_prev = 0; m_state = 0; m_good = 0; m_idx = 0; m_ok = 1; m_err = 0;
        end else begin
            if (v) begin
                ones = $countones(c);
                succ = (m_prev == 4'b0000 || m_prev == 4'b0001) ? 4'b1000 : m_prev >> 1;
                if (ones == 0) begin
                    m_ok = 1; er = (m_state == 2);
                    m_prev = 0; m_state = 0; m_good = 0;
                end else if (ones > 1) begin
                    m_ok = 0; er = 1;
                    m_prev = 0; m_state = 0; m_good = 0;
                end else begin
                    m_ok = 1; iv = 1;
                    case (c)
                        4'b1000: m_idx = 2'd0;
                        4'b0100: m_idx = 2'd1;
                        4'b0010: m_idx = 2'd2;
                        default: m_idx = 2'd3;
                    endcase
                    if (c == succ) begin
                        wr = (m_prev == 4'b0001);
                        if (m_state != 2) begin
                            if (m_prev != 0) m_good = m_good + 1;
                            if (m_good >= 4) begin
                                m_state = 2; m_good = 0;
                            end else begin
                                m_state = 1;
                            end
                        end
                    end else begin
                        er = 1; m_state = 0; m_good = 0;
                    end
                    m_prev = c;
                end
            end
`ifdef RING_SEQ_CHECKER_ERR_CNT_EN
            if (er) m_err = clr ? 1 : (m_err < 3 ? m_err + 1 : 3);
            else if (clr) m_err = 0;
`endif
        end
        sb.push_back({m_idx, iv, m_ok, wr, (m_state == 2), er, 2'(m_err)});
        reset = r; ring_valid = v; ring_in = c; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);
        exp_v = sb.pop_front(); exp_v = sb.pop_front(); act_v = actual();
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL reset_model act=%b exp=%b", act_v, exp_v);
        end
        checks++;
        if (act_v !== 9'b00_0100_0_00) begin
            failures++;
            $display("FAIL reset_values act=%b exp=%b", act_v, 9'b000100000);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq[6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic [1:0] eidx[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 6; i++) begin
            step(0, 1, seq[i], 0);
            exp_v = sb.pop_front(); act_v = actual();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL seq_%0d act=%b exp=%b", i, act_v, exp_v);
            end
            checks++;
            if (idx !== eidx[i] || seq_err !== 1'b0) begin
                failures++;
                $display("FAIL seq_idx_%0d act=%0d/%b exp=%0d/0", i, idx, seq_err, eidx[i]);
            end
        end
        checks++;
        if (locked !== 1'b1 || wrap !== 1'b1) begin
            failures++;
            $display("FAIL seq_lock_wrap act=%b%b exp=11", locked, wrap);
        end
    endtask

    task automatic test_error_relock();
        logic [3:0] seq[5] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, seq[i], 0);
            exp_v = sb.pop_front(); act_v = actual();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL relock_%0d act=%b exp=%b", i, act_v, exp_v);
            end
            if (i == 0) begin
                checks++;
                if (seq_err !== 1'b1 || locked !== 1'b0 || idx !== 2'd2) begin
                    failures++;
                    $display("FAIL bad_succ act=%b%b%0d exp=102", seq_err, locked, idx);
                end
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relocked act=%b exp=1", locked);
        end
    endtask

    task automatic test_illegal();
        step(0, 1, 4'b0110, 0);
        exp_v = sb.pop_front(); act_v = actual();
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL illegal act=%b exp=%b", act_v, exp_v);
        end
        checks++;
        if (seq_err !== 1'b1 || onehot_ok !== 1'b0 || idx !== 2'd2 || locked !== 1'b0) begin
            failures++;
            $display("FAIL illegal_flags act=%b%b%0d%b exp=1020", seq_err, onehot_ok, idx, locked);
        end
    endtask

    task automatic test_hold();
        logic [3:0] seq[9] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000,
                               4'b1111, 4'b0110, 4'b0011, 4'b0100};
        logic       vld[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            step(0, vld[i], seq[i], 0);
            exp_v = sb.pop_front(); act_v = actual();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL hold_%0d act=%b exp=%b", i, act_v, exp_v);
            end
            if (i >= 5) begin
                checks++;
                if (seq_err !== 1'b0 || locked !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_lock_%0d act=%b%b exp=01", i, seq_err, locked);
                end
            end
        end
    endtask

    task automatic test_err_count();
        logic [3:0] code[8] = '{4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                4'b0110, 4'b0110, 4'b0000};
        logic       vld[8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic       clr[8]  = '{1, 0, 0, 0, 0, 0, 1, 1};
        logic [1:0] ecnt[8];
`ifdef RING_SEQ_CHECKER_ERR_CNT_EN
        ecnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
`else
        ecnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int i = 0; i < 8; i++) begin
            step(0, vld[i], code[i], clr[i]);
            exp_v = sb.pop_front(); act_v = actual();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL errcnt_%0d act=%b exp=%b", i, act_v, exp_v);
            end
            checks++;
            if (err_count !== ecnt[i]) begin
                failures++;
                $display("FAIL errcnt_val_%0d act=%0d exp=%0d", i, err_count, ecnt[i]);
            end
        end
    endtask

    task automatic test_reset_locked();
        logic [3:0] seq[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, seq[i], 0);
            exp_v = sb.pop_front(); act_v = actual();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL rl_seq_%0d act=%b exp=%b", i, act_v, exp_v);
            end
        end
        step(1, 1, 4'b0100, 1);
        exp_v = sb.pop_front(); act_v = actual();
        checks++;
        if (act_v !== 9'b00_0100_0_00 || act_v !== exp_v) begin
            failures++;
            $display("FAIL reset_locked act=%b exp=%b", act_v, 9'b000100000);
        end
        step(0, 1, 4'b1000, 0);
        exp_v = sb.pop_front(); act_v = actual();
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL post_reset act=%b exp=%b", act_v, exp_v);
        end
    endtask

    initial begin
        reset = 1; ring_valid = 0; ring_in = 0; err_clr = 0;
        m_prev = 0; m_state = 0; m_good = 0; m_idx = 0; m_ok = 1; m_err = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequence();
        test_error_relock();
        test_illegal();
        test_hold();
        test_err_count();
        test_reset_locked();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left act=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
